mips_alu_seq: RTL and testbench
===============================

# mips_alu_seq

Parametrised, multi-cycle successor to the MIPS datapath ALU. Single-cycle logic, arithmetic, compare and shift operations complete with fixed one-cycle latency. Iterative multiply and unsigned divide take WIDTH cycles and write a HI/LO pair. A valid/ready handshake on the input side and a one-cycle done strobe on the output side let the execute stage stall correctly on long operations.

## Interface
- WIDTH, 32: operand/result width in bits; must be ≥ 4 and a power of two.
- SHW, $clog2(WIDTH): shift-amount width (derived; not overridden).
- clk  in  1: clock; all logic updates on the rising edge.
- reset  in  1: reset; synchronous, active-high.
- in_valid  in  1: operation request.
- in_ready  out  1: block can accept; a transfer occurs when in_valid && in_ready at a rising edge.
- operation  in  4: opcode, sampled on transfer.
- data0  in  WIDTH: operand A, sampled on transfer.
- data1  in  WIDTH: operand B, sampled on transfer.
- out_valid  out  1: one-cycle strobe; result/hi/lo/zero/overflow are valid in this cycle.
- result  out  WIDTH: primary result (LO for MULT/DIVU).
- hi  out  WIDTH: MULT upper product / DIVU remainder; holds its last value otherwise.
- zero  out  1: result == 0.
- overflow  out  1: signed overflow for ADD/SUB; 0 for all other ops.

## Operation
- Opcodes: 0 AND; 1 OR; 2 ADD; 3 XOR; 4 SLL (data1 << data0[SHW-1:0]); 5 SRL (logical); 6 SUB (data0 − data1); 7 SLT (signed, result = {0…,1} or 0); 8 SRA (arithmetic); 12 NOR; 9 MULT (unsigned, 2·WIDTH product → {hi,result}); 10 DIVU (result = quotient, hi = remainder).
- Undefined opcodes: result = 0, zero = 1, overflow = 0, hi unchanged, out_valid still pulses.
- ADD/SUB wrap modulo 2^WIDTH. Overflow is set when the operand signs meet the usual signed-overflow rule.
- Divide by zero: result = all ones, hi = data0, no error flag.
- hi is written only by MULT/DIVU. zero and overflow are recomputed for every op.
- State machine:
  - IDLE → IDLE on a single-cycle op.
  - IDLE → BUSY on MULT/DIVU transfer; iteration counter loaded with WIDTH.
  - BUSY → IDLE when the counter reaches 0 at the final iteration edge.
- MULT iteration: shift-add, one multiplier bit per cycle.
- DIVU iteration: restoring, one quotient bit per cycle.

## Timing
- Reset values: in_ready = 1, out_valid = 0, result = 0, hi = 0, zero = 1, overflow = 0, state IDLE, counter 0.
- Single-cycle op accepted at edge N: outputs updated at edge N; out_valid high for cycle N→N+1; latency 1.
- Back-to-back single-cycle ops are accepted every cycle at full throughput.
- MULT/DIVU accepted at edge N: in_ready drops after edge N. WIDTH iterations occur at edges N+1…N+WIDTH; outputs are written at edge N+WIDTH.
- At edge N+WIDTH: out_valid high for one cycle and in_ready returns to 1 in that same cycle. A new request can therefore be accepted at edge N+WIDTH+1.
- in_valid while BUSY: ignored, not queued. The requester must hold it.
- No output backpressure: out_valid is a strobe. The consumer must capture it.
- Reset asserted mid-MULT/DIVU: the operation is abandoned. All outputs return to reset values at that edge and no out_valid is produced.
- reset and in_valid in the same cycle: reset wins and nothing is accepted.
- Outputs other than out_valid hold their values between strobes.

## Structure
- Package mips_alu_pkg holds:
  - opcode localparams (OP_AND … OP_DIVU);
  - state enum {IDLE, BUSY};
  - a function for signed-overflow detection.
- Sub-module mips_alu_muldiv contains the iterative multiply/divide datapath and counter. It has a start/op input and a done/hi/lo output.
- The top level holds:
  - the single-cycle combinational ops;
  - the handshake FSM;
  - the output registers.

## Test plan
- Reset then ADD 0x7FFFFFFF + 1 (WIDTH=32) → next cycle: out_valid = 1, result = 0x80000000, overflow = 1, zero = 0.
- SUB 5 − 5, then SLT 0xFFFFFFFF vs 1, then SRA 0x80000000 by 4, issued on consecutive cycles → results 0 (zero = 1), 1, 0xF8000000 on three consecutive out_valid cycles.
- MULT 0xFFFFFFFF × 0xFFFFFFFF:
  - in_ready low for 32 cycles;
  - in_valid held during BUSY is not accepted;
  - out_valid at cycle 32 after accept with hi = 0xFFFFFFFE, result = 0x00000001.
- DIVU 100 / 7 → result = 14, hi = 2. DIVU 9 / 0 → result = 0xFFFFFFFF, hi = 9.
- Reset asserted on iteration 10 of a MULT → no out_valid, outputs at reset values, in_ready = 1. A following ADD 1 + 1 returns 2.
- Opcode 15 → result = 0, zero = 1, out_valid pulses. Repeat with WIDTH=8 and check MULT 0xFF × 0x02 → hi = 0x01, result = 0xFE after 8 cycles.

Source files
------------

// File: rtl/mips_alu_pkg.sv
// Shared definitions for the sequential MIPS ALU.
//   - 4-bit opcode encodings
//   - handshake FSM state type
//   - signed-overflow helper for ADD/SUB
package mips_alu_pkg;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_SLL  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_MULT = 4'd9;
  localparam logic [3:0] OP_DIVU = 4'd10;
  localparam logic [3:0] OP_NOR  = 4'd12;

  typedef enum logic {StIdle, StBusy} state_e;

  // Subtraction is addition of the inverted B operand, so flip B's sign for SUB.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic r_msb, input logic is_sub);
    logic b_eff;
    b_eff = b_msb ^ is_sub;
    return (a_msb == b_eff) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/mips_alu_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per cycle.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   start_i         : load operands and begin WIDTH iterations
//   is_div_i        : 1 = divide, 0 = multiply (sampled with start_i)
//   a_i, b_i        : multiplier/dividend, multiplicand/divisor
//   done_o          : the coming edge performs the final iteration
//   hi_o, lo_o      : accumulator value produced by the coming edge
//                     (product {hi,lo} or {remainder,quotient} when done_o)
module mips_alu_muldiv
  import mips_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               div_q, div_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0]   hi_part, lo_part;
  logic [WIDTH:0]     mul_sum, div_cand, div_rem;
  logic               div_ge;
  logic [2*WIDTH-1:0] step;

  always_comb begin
    hi_part  = acc_q[2*WIDTH-1:WIDTH];
    lo_part  = acc_q[WIDTH-1:0];
    // Multiply: acc = {partial product, remaining multiplier bits}.
    mul_sum  = {1'b0, hi_part} + (lo_part[0] ? {1'b0, opnd_q} : '0);
    // Divide: acc = {partial remainder, dividend bits / quotient bits}.
    // A zero divisor always "fits", giving an all-ones quotient and remainder = dividend.
    div_cand = {hi_part, lo_part[WIDTH-1]};
    div_ge   = (div_cand >= {1'b0, opnd_q});
    div_rem  = div_ge ? (div_cand - {1'b0, opnd_q}) : div_cand;
    step     = div_q ? {div_rem[WIDTH-1:0], lo_part[WIDTH-2:0], div_ge}
                     : {mul_sum, lo_part[WIDTH-1:1]};

    acc_d  = acc_q;
    opnd_d = opnd_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    if (start_i) begin
      acc_d  = {{WIDTH{1'b0}}, a_i};
      opnd_d = b_i;
      div_d  = is_div_i;
      cnt_d  = CntW'(WIDTH);
    end else if (cnt_q != '0) begin
      acc_d = step;
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == CntW'(1));
  assign hi_o   = step[2*WIDTH-1:WIDTH];
  assign lo_o   = step[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/mips_alu_seq.sv
// Multi-cycle MIPS ALU: single-cycle logic/arith/compare/shift ops with latency 1,
// iterative MULT/DIVU taking WIDTH cycles and writing a HI/LO pair.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   in_valid / in_ready   : request handshake, transfer when both high at an edge
//   operation, data0/1    : opcode and operands, sampled on transfer
//   out_valid             : one-cycle strobe marking fresh result/hi/zero/overflow
//   result, hi            : primary result (LO) and MULT upper / DIVU remainder
//   zero, overflow        : result == 0, signed overflow of ADD/SUB
module mips_alu_seq
  import mips_alu_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             overflow
);

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] alu_res, add_res, sub_res;
  logic             alu_ovf, is_long, md_start, md_done;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] md_hi, md_lo;

  assign shamt   = data0[SHW-1:0];
  assign add_res = data0 + data1;
  assign sub_res = data0 - data1;
  assign is_long = (operation == OP_MULT) || (operation == OP_DIVU);

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (operation)
      OP_AND:  alu_res = data0 & data1;
      OP_OR:   alu_res = data0 | data1;
      OP_XOR:  alu_res = data0 ^ data1;
      OP_NOR:  alu_res = ~(data0 | data1);
      OP_ADD: begin
        alu_res = add_res;
        alu_ovf = signed_ovf(data0[WIDTH-1], data1[WIDTH-1], add_res[WIDTH-1], 1'b0);
      end
      OP_SUB: begin
        alu_res = sub_res;
        alu_ovf = signed_ovf(data0[WIDTH-1], data1[WIDTH-1], sub_res[WIDTH-1], 1'b1);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(data0) < $signed(data1))};
      OP_SLL:  alu_res = data1 << shamt;
      OP_SRL:  alu_res = data1 >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(data1) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = 1'b0;
    result_d    = result_q;
    hi_d        = hi_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    md_start    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (is_long) begin
            md_start = 1'b1;
            state_d  = StBusy;
          end else begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            ovf_d       = alu_ovf;
          end
        end
      end
      StBusy: begin
        if (md_done) begin
          state_d     = StIdle;
          out_valid_d = 1'b1;
          result_d    = md_lo;
          hi_d        = md_hi;
          zero_d      = (md_lo == '0);
          ovf_d       = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      hi_q        <= '0;
      zero_q      <= 1'b1;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      hi_q        <= hi_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
    end
  end

  mips_alu_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk     (clk),
    .reset   (reset),
    .start_i (md_start),
    .is_div_i(operation == OP_DIVU),
    .a_i     (data0),
    .b_i     (data1),
    .done_o  (md_done),
    .hi_o    (md_hi),
    .lo_o    (md_lo)
  );

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign hi        = hi_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_mips_alu_seq.sv
module tb_mips_alu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, zero, overflow;
  logic [3:0]  operation;
  logic [31:0] data0, data1, result, hi;

  logic       v8, rdy8, ov8, z8, of8;
  logic [3:0] op8;
  logic [7:0] a8, b8, res8, hi8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_alu_seq #(.WIDTH(32)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .operation(operation), .data0(data0), .data1(data1), .out_valid(out_valid),
    .result(result), .hi(hi), .zero(zero), .overflow(overflow)
  );

  mips_alu_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(v8), .in_ready(rdy8),
    .operation(op8), .data0(a8), .data1(b8), .out_valid(ov8),
    .result(res8), .hi(hi8), .zero(z8), .overflow(of8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- Behavioural model of the 32-bit instance ----------------
  bit          m_live = 0;
  logic        m_ready, m_valid, m_zero, m_ovf;
  logic [31:0] m_res, m_hi, m_pend_lo, m_pend_hi;
  int          m_left;

  task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, s;
    longint unsigned p;
    logic [31:0] r;
    logic o;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 0;
    o = 0;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd3:  r = a ^ b;
      4'd12: r = ~(a | b);
      4'd2: begin
        r = a + b; s = sa + sb;
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd6: begin
        r = a - b; s = sa - sb;
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd4:  r = b << a[4:0];
      4'd5:  r = b >> a[4:0];
      4'd8:  r = $unsigned($signed(b) >>> a[4:0]);
      4'd9: begin
        p = longint'(a) * longint'(b);
        m_pend_hi = p[63:32]; m_pend_lo = p[31:0];
        m_left = 32; m_ready = 0;
        return;
      end
      4'd10: begin
        if (b == 0) begin m_pend_lo = 32'hFFFF_FFFF; m_pend_hi = a; end
        else begin m_pend_lo = a / b; m_pend_hi = a % b; end
        m_left = 32; m_ready = 0;
        return;
      end
      default: r = 0;
    endcase
    m_valid = 1; m_res = r; m_zero = (r == 0); m_ovf = o;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_live = 1; m_ready = 1; m_valid = 0; m_res = 0; m_hi = 0;
      m_zero = 1; m_ovf = 0; m_left = 0;
    end else if (m_live) begin
      m_valid = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_valid = 1; m_res = m_pend_lo; m_hi = m_pend_hi;
          m_zero = (m_pend_lo == 0); m_ovf = 0; m_ready = 1;
        end
      end else if (in_valid) begin
        model_op(operation, data0, data1);
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("model in_ready", 64'(in_ready), 64'(m_ready));
      chk("model out_valid", 64'(out_valid), 64'(m_valid));
      chk("model result", 64'(result), 64'(m_res));
      chk("model hi", 64'(hi), 64'(m_hi));
      chk("model zero", 64'(zero), 64'(m_zero));
      chk("model overflow", 64'(overflow), 64'(m_ovf));
    end
  end

  // ---------------- Directed stimulus with literal expectations ----------------
  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1; operation = op; data0 = a; data1 = b;
  endtask

  // Waits (bounded) for out_valid; counts negedges seen and those with in_ready low.
  task automatic wait_valid(output int cyc, output int lowcnt);
    cyc = 0; lowcnt = 0;
    while (out_valid !== 1'b1 && cyc < 100) begin
      if (in_ready === 1'b0) lowcnt++;
      cyc++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, r;
    logic        o;
  } vec_t;

  vec_t vecs[8] = '{
    '{4'd0,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0},
    '{4'd1,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0},
    '{4'd3,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0},
    '{4'd12, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 1'b0},
    '{4'd4,  32'd8,         32'h0000_0001, 32'h0000_0100, 1'b0},
    '{4'd5,  32'd4,         32'h8000_0000, 32'h0800_0000, 1'b0},
    '{4'd6,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1},
    '{4'd7,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0}
  };

  initial begin
    int cyc, lowcnt;
    reset = 1; in_valid = 0; operation = 0; data0 = 0; data1 = 0;
    v8 = 0; op8 = 0; a8 = 0; b8 = 0;
    repeat (2) @(negedge clk);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset result", 64'(result), 64'd0);
    chk("reset zero", 64'(zero), 64'd1);
    reset = 0;

    drive(4'd2, 32'h7FFF_FFFF, 32'h1);
    @(negedge clk); in_valid = 0;
    chk("add valid", 64'(out_valid), 64'd1);
    chk("add result", 64'(result), 64'h8000_0000);
    chk("add overflow", 64'(overflow), 64'd1);
    chk("add zero", 64'(zero), 64'd0);

    drive(4'd6, 32'd5, 32'd5);
    @(negedge clk);
    chk("sub result", 64'(result), 64'd0);
    chk("sub zero", 64'(zero), 64'd1);
    drive(4'd7, 32'hFFFF_FFFF, 32'd1);
    @(negedge clk);
    chk("slt result", 64'(result), 64'd1);
    chk("slt valid", 64'(out_valid), 64'd1);
    drive(4'd8, 32'd4, 32'h8000_0000);
    @(negedge clk);
    chk("sra result", 64'(result), 64'hF800_0000);
    chk("sra valid", 64'(out_valid), 64'd1);

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      @(negedge clk);
      chk($sformatf("vec%0d result", i), 64'(result), 64'(vecs[i].r));
      chk($sformatf("vec%0d overflow", i), 64'(overflow), 64'(vecs[i].o));
    end
    in_valid = 0;
    @(negedge clk);

    // MULT with an ADD held on in_valid throughout BUSY.
    drive(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    drive(4'd2, 32'd3, 32'd4);
    wait_valid(cyc, lowcnt);
    chk("mult latency", 64'(cyc), 64'd32);
    chk("mult ready low cycles", 64'(lowcnt), 64'd32);
    chk("mult ready back", 64'(in_ready), 64'd1);
    chk("mult hi", 64'(hi), 64'hFFFF_FFFE);
    chk("mult lo", 64'(result), 64'h1);
    @(negedge clk); in_valid = 0;
    chk("held add valid", 64'(out_valid), 64'd1);
    chk("held add result", 64'(result), 64'd7);

    drive(4'd10, 32'd100, 32'd7);
    @(negedge clk); in_valid = 0;
    wait_valid(cyc, lowcnt);
    chk("divu quotient", 64'(result), 64'd14);
    chk("divu remainder", 64'(hi), 64'd2);

    drive(4'd10, 32'd9, 32'd0);
    @(negedge clk); in_valid = 0;
    wait_valid(cyc, lowcnt);
    chk("div0 quotient", 64'(result), 64'hFFFF_FFFF);
    chk("div0 remainder", 64'(hi), 64'd9);

    // Reset on the 10th iteration of a MULT.
    drive(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk); in_valid = 0;
    repeat (9) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("abort out_valid", 64'(out_valid), 64'd0);
    chk("abort result", 64'(result), 64'd0);
    chk("abort hi", 64'(hi), 64'd0);
    chk("abort zero", 64'(zero), 64'd1);
    chk("abort in_ready", 64'(in_ready), 64'd1);
    drive(4'd2, 32'd1, 32'd1);
    @(negedge clk); in_valid = 0;
    chk("post-abort add", 64'(result), 64'd2);
    repeat (40) @(negedge clk);

    drive(4'd15, 32'd3, 32'd5);
    @(negedge clk); in_valid = 0;
    chk("undef valid", 64'(out_valid), 64'd1);
    chk("undef result", 64'(result), 64'd0);
    chk("undef zero", 64'(zero), 64'd1);

    // WIDTH=8 instance.
    v8 = 1; op8 = 4'd9; a8 = 8'hFF; b8 = 8'h02;
    @(negedge clk); v8 = 0;
    cyc = 0; lowcnt = 0;
    while (ov8 !== 1'b1 && cyc < 100) begin
      if (rdy8 === 1'b0) lowcnt++;
      cyc++;
      @(negedge clk);
    end
    chk("w8 mult latency", 64'(cyc), 64'd8);
    chk("w8 ready low cycles", 64'(lowcnt), 64'd8);
    chk("w8 mult hi", 64'(hi8), 64'h01);
    chk("w8 mult lo", 64'(res8), 64'hFE);
    chk("w8 mult zero", 64'(z8), 64'd0);
    v8 = 1; op8 = 4'd15; a8 = 8'h11; b8 = 8'h22;
    @(negedge clk); v8 = 0;
    chk("w8 undef valid", 64'(ov8), 64'd1);
    chk("w8 undef result", 64'(res8), 64'd0);
    chk("w8 undef zero", 64'(z8), 64'd1);
    chk("w8 undef overflow", 64'(of8), 64'd0);
    chk("w8 undef hi kept", 64'(hi8), 64'h01);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
